pic_feeder: RTL and testbench
=============================

PIC_FEEDER -- requirements
Module: pic_feeder

Interface
REQ-001 Parameter WIDTH, default 8: pixel bit width.
REQ-002 Parameter pic_size, default 28: image side length in pixels.
REQ-003 Parameter channel, default 3: channels per image.
REQ-004 Derived constant TOTAL = channel*pic_size*pic_size (2352 at defaults); AW = $clog2(TOTAL).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 rst  in  1  reset; asynchronous, active-high.
REQ-008 load_valid  in  1  load pixel offered.
REQ-009 load_data  in  WIDTH  load pixel value.
REQ-010 load_ready  out  1  feeder accepts a load pixel this cycle.
REQ-011 feed_start  in  1  request to stream the stored image.
REQ-012 need_pic  in  1  downstream convolution engine wants a pixel.
REQ-013 pic  out  WIDTH  streamed pixel, registered.
REQ-014 pic_valid  out  1  pic holds a valid pixel, registered.
REQ-015 pic_addr  out  AW  index of the pixel currently on pic.
REQ-016 conv_start  out  1  held high for the whole FEED state.
REQ-017 feed_done  out  1  one-cycle pulse after the last pixel transfers.

Function
REQ-018 Internal buffer: TOTAL x WIDTH. Order is channel-major, then row, then column (index = c*pic_size^2 + r*pic_size + col).
REQ-019 States: IDLE (buffer empty), LOAD, READY, FEED, DONE.
REQ-020 Load transfer occurs when load_valid && load_ready. Data is written at the load counter, which starts at 0 and increments by 1 per transfer.
REQ-021 load_ready = 1 in IDLE, LOAD, and READY when feed_start = 0; load_ready = 0 otherwise.
REQ-022 IDLE -> LOAD on the first load transfer (index 0).
REQ-023 LOAD -> READY on the transfer at index TOTAL-1. Gaps in load_valid are allowed.
REQ-024 A load transfer in READY restarts at index 0 and enters LOAD. The old image is considered invalid.
REQ-025 READY -> FEED on feed_start. feed_start wins over a simultaneous load_valid, and that load pixel is not accepted.
REQ-026 feed_start is ignored in IDLE, LOAD, FEED, and DONE.
REQ-027 FEED entry: pixel 0 is presented within 2 cycles; pic_valid = 1, pic_addr = 0.
REQ-028 Pixel transfer occurs on a cycle where pic_valid && need_pic.
REQ-029 After a transfer, the next pixel is valid on the following cycle. Throughput SHALL be 1 pixel/cycle while need_pic stays high.
REQ-030 With need_pic low, pic, pic_valid, and pic_addr hold unchanged.
REQ-031 Once presented, a pixel is never withdrawn or changed until transferred.
REQ-032 On transfer of index TOTAL-1: pic_valid = 0 next cycle, conv_start = 0, enter DONE.
REQ-033 DONE lasts 1 cycle with feed_done = 1, then enters READY. The image is retained, so feed_start may replay it.
REQ-034 The pixel counter never wraps past TOTAL-1. A need_pic held high after the last transfer produces no further pixels.

Reset
REQ-035 While rst is high: state = IDLE, load and feed counters = 0, pic = 0, pic_valid = 0, pic_addr = 0, conv_start = 0, feed_done = 0, load_ready = 0.
REQ-036 After rst deasserts, load_ready = 1 from the first rising edge.
REQ-037 Buffer contents are not reset and are treated as invalid.
REQ-038 Reset asserted mid-LOAD or mid-FEED aborts immediately. No feed_done pulse occurs, and a new full load is required.

Structure
REQ-039 Package conv_pkg holds:
- the state enum type (IDLE, LOAD, READY, FEED, DONE);
- the TOTAL and AW calculation functions;
- the default WIDTH, pic_size, and channel constants shared with conv_control.
REQ-040 Sub-module pic_buffer: single-port-write, single-port-read RAM, TOTAL x WIDTH, with synchronous 1-cycle read. pic_feeder owns prefetch and the output register.

Verification
REQ-041 Reset, load 2352 bytes value (i mod 256) with load_valid constantly high, then pulse feed_start, need_pic constantly high:
- pixels 0..2351 arrive in order with pic = i mod 256 on consecutive cycles;
- feed_done pulses exactly once;
- conv_start is high exactly across FEED.
REQ-042 Backpressure, need_pic toggling 1,0,0,1 repeatedly: no pixel is lost or duplicated, and pic is stable while need_pic = 0.
REQ-043 feed_start asserted during LOAD at index 100: it is ignored; the load completes, and the state reaches READY only at index 2351.
REQ-044 rst pulsed after 500 transferred pixels: outputs reach reset values at once, no feed_done pulse occurs, and feed_start is ignored until a full reload.
REQ-045 feed_start and load_valid high together in READY: FEED is entered, load_ready = 0, and pixel 0 equals the previously stored value.
REQ-046 Second feed_start after DONE with no reload: identical 2352-pixel sequence is replayed.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution front end.
// Defaults here are also used by conv_control so both sides agree on image geometry.
package conv_pkg;
  localparam int WIDTH_D    = 8;
  localparam int PIC_SIZE_D = 28;
  localparam int CHANNEL_D  = 3;

  typedef enum logic [2:0] {IDLE, LOAD, READY, FEED, DONE} feed_state_t;

  function automatic int calc_total(input int ch, input int sz);
    return ch * sz * sz;
  endfunction

  function automatic int calc_aw(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction
endpackage

// File: rtl/pic_feeder_if.sv
// Load and stream handshake bundle between the image source/engine and pic_feeder.
interface pic_feeder_if
  import conv_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int AW    = calc_aw(calc_total(CHANNEL_D, PIC_SIZE_D))
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             feed_start;
  logic             need_pic;
  logic [WIDTH-1:0] pic;
  logic             pic_valid;
  logic [AW-1:0]    pic_addr;
  logic             conv_start;
  logic             feed_done;

  modport master (
    output load_valid, load_data, feed_start, need_pic,
    input  load_ready, pic, pic_valid, pic_addr, conv_start, feed_done
  );

  modport slave (
    input  load_valid, load_data, feed_start, need_pic,
    output load_ready, pic, pic_valid, pic_addr, conv_start, feed_done
  );
endinterface

// File: rtl/pic_buffer.sv
// Image store: one write port, one read port with a registered 1-cycle read.
// Contents are never reset; the feeder's state decides whether they are meaningful.
module pic_buffer
  import conv_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int DEPTH = calc_total(CHANNEL_D, PIC_SIZE_D),
  parameter int AW    = calc_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/pic_feeder.sv
// Buffers one channel-major image and streams it to the convolution engine
// one pixel per cycle under need_pic backpressure; the image can be replayed.
module pic_feeder
  import conv_pkg::*;
#(
  parameter int WIDTH    = WIDTH_D,
  parameter int pic_size = PIC_SIZE_D,
  parameter int channel  = CHANNEL_D
) (
  input logic        clk,
  input logic        rst,
  pic_feeder_if.slave bus
);
  localparam int TOTAL = calc_total(channel, pic_size);
  localparam int AW    = calc_aw(TOTAL);
  localparam logic [AW-1:0] LAST = AW'(TOTAL - 1);

  feed_state_t      state;
  logic [AW-1:0]    load_cnt;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             load_xfer, feed_go, pix_xfer;
  int               rd_idx;

  // feed_start only has meaning in READY, where it also blocks a concurrent load
  assign bus.load_ready = !rst && (state == IDLE || state == LOAD ||
                                   (state == READY && !bus.feed_start));
  assign load_xfer = bus.load_valid && bus.load_ready;
  assign feed_go   = (state == READY) && bus.feed_start;
  assign pix_xfer  = (state == FEED) && bus.pic_valid && bus.need_pic;

  // rd_data always holds the pixel after the one on pic, so a transfer can
  // refill pic from rd_data while the RAM fetches two ahead.
  always_comb begin
    rd_idx = 0;
    if (state == FEED)
      rd_idx = !bus.pic_valid ? 1 : int'(bus.pic_addr) + (pix_xfer ? 2 : 1);
    rd_addr = (rd_idx >= TOTAL) ? LAST : AW'(rd_idx);
  end

  pic_buffer #(.WIDTH(WIDTH), .DEPTH(TOTAL), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (load_xfer),
    .waddr (load_cnt),
    .wdata (bus.load_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      load_cnt       <= '0;
      bus.pic        <= '0;
      bus.pic_valid  <= 1'b0;
      bus.pic_addr   <= '0;
      bus.conv_start <= 1'b0;
      bus.feed_done  <= 1'b0;
    end else begin
      bus.feed_done <= 1'b0;
      case (state)
        IDLE, LOAD, READY: begin
          if (feed_go) begin
            state          <= FEED;
            bus.conv_start <= 1'b1;
          end else if (load_xfer) begin
            // load_cnt is 0 outside LOAD, so a load in READY restarts the image
            if (load_cnt == LAST) begin
              state    <= READY;
              load_cnt <= '0;
            end else begin
              state    <= LOAD;
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        FEED: begin
          if (!bus.pic_valid) begin
            bus.pic       <= rd_data;
            bus.pic_addr  <= '0;
            bus.pic_valid <= 1'b1;
          end else if (pix_xfer) begin
            if (bus.pic_addr == LAST) begin
              bus.pic_valid  <= 1'b0;
              bus.conv_start <= 1'b0;
              bus.feed_done  <= 1'b1;
              state          <= DONE;
            end else begin
              bus.pic      <= rd_data;
              bus.pic_addr <= bus.pic_addr + 1'b1;
            end
          end
        end
        DONE:    state <= READY;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pic_feeder.sv
// Directed bench for pic_feeder: vector table for reset/early load, then
// hand-written load, feed, backpressure, replay and abort sequences.
module tb_pic_feeder;
  localparam int TOTAL = 2352;
  localparam int AW    = 12;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   ld_err   = 0;
  int   model [TOTAL];

  pic_feeder_if #(.WIDTH(8), .AW(AW)) bus ();

  pic_feeder #(.WIDTH(8), .pic_size(28), .channel(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, lv;
    logic [7:0] d;
    logic       fs, np;
    logic       exp_ready, exp_pv, exp_cs, exp_fd;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Called at a falling edge; each pixel offered for one cycle, optional idle gap.
  task automatic load_range(input int lo, input int hi, input int gap);
    for (int i = lo; i < hi; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 8'(model[i]);
      #1;
      if (bus.load_ready !== 1'b1) ld_err++;
      @(negedge clk);
      if (gap != 0 && (i % gap) == 0) begin
        bus.load_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.load_valid = 1'b0;
  endtask

  // Called at the falling edge right after the edge that entered FEED.
  task automatic run_feed(input string tag, input int pat, input int abort_at,
                          output int first_pic);
    int nxt = 0, first_cyc = -1, done_cnt = 0, post = 0;
    int ord_err = 0, stab_err = 0, gap_err = 0, cs_err = 0, fd_err = 0;
    logic prev_pv = 1'b0, prev_xfer = 1'b0, np;
    logic [7:0] prev_pic = '0;
    logic [AW-1:0] prev_addr = '0;
    int finished = 0;
    first_pic = -1;
    for (int cyc = 0; cyc < 12000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (abort_at > 0 && nxt == abort_at) begin finished = 1; break; end
      if (bus.feed_done) begin
        done_cnt++;
        if (nxt < TOTAL) fd_err++;
      end
      if (bus.conv_start !== (nxt < TOTAL)) cs_err++;
      if (bus.pic_valid) begin
        if (first_cyc < 0) begin first_cyc = cyc; first_pic = int'(bus.pic); end
        if (nxt >= TOTAL) ord_err++;
        else if (bus.pic_addr !== AW'(nxt) || bus.pic !== 8'(model[nxt])) ord_err++;
      end else if (first_cyc >= 0 && nxt < TOTAL) gap_err++;
      if (prev_pv && !prev_xfer &&
          (!bus.pic_valid || bus.pic !== prev_pic || bus.pic_addr !== prev_addr))
        stab_err++;
      np = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      bus.need_pic = np;
      prev_pv   = bus.pic_valid;
      prev_pic  = bus.pic;
      prev_addr = bus.pic_addr;
      prev_xfer = bus.pic_valid && np;
      if (prev_xfer) nxt++;
      if (done_cnt > 0) post++;
      if (post > 3) begin finished = 1; break; end
    end
    bus.need_pic = 1'b0;
    chk({tag, "_finished"}, finished, 1);
    chk({tag, "_order"}, ord_err, 0);
    chk({tag, "_stable_on_stall"}, stab_err, 0);
    chk({tag, "_no_gap"}, gap_err, 0);
    chk({tag, "_conv_start"}, cs_err, 0);
    chk({tag, "_done_early"}, fd_err, 0);
    chk({tag, "_pix0_within_2"}, int'(first_cyc >= 0 && first_cyc <= 2), 1);
    if (abort_at == 0) begin
      chk({tag, "_count"}, nxt, TOTAL);
      chk({tag, "_done_pulses"}, done_cnt, 1);
    end else begin
      chk({tag, "_count_at_abort"}, nxt, abort_at);
      chk({tag, "_done_before_abort"}, done_cnt, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [7];
    int   p0;
    int   seen_cs, seen_fd;

    rst = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.feed_start = 1'b0;
    bus.need_pic   = 1'b0;
    foreach (model[i]) model[i] = i % 256;

    //           rst   lv    d      fs    np    ready pv    cs    fd
    tbl[0] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    @(negedge clk);
    chk("reset_pic", int'(bus.pic), 0);
    chk("reset_pic_addr", int'(bus.pic_addr), 0);

    foreach (tbl[k]) begin
      rst            = tbl[k].rst;
      bus.load_valid = tbl[k].lv;
      bus.load_data  = tbl[k].d;
      bus.feed_start = tbl[k].fs;
      bus.need_pic   = tbl[k].np;
      #1;
      chk($sformatf("vec%0d_load_ready", k), int'(bus.load_ready), int'(tbl[k].exp_ready));
      @(negedge clk);
      chk($sformatf("vec%0d_pic_valid", k), int'(bus.pic_valid), int'(tbl[k].exp_pv));
      chk($sformatf("vec%0d_conv_start", k), int'(bus.conv_start), int'(tbl[k].exp_cs));
      chk($sformatf("vec%0d_feed_done", k), int'(bus.feed_done), int'(tbl[k].exp_fd));
    end
    bus.feed_start = 1'b0;
    bus.load_valid = 1'b0;

    // feed_start in LOAD at index 100 and just before the final pixel is ignored
    load_range(3, 100, 0);
    bus.feed_start = 1'b1;
    load_range(100, 101, 0);
    bus.feed_start = 1'b0;
    chk("fs_in_load_idx100", int'(bus.conv_start), 0);
    load_range(101, TOTAL - 1, 0);
    bus.feed_start = 1'b1;
    @(negedge clk);
    bus.feed_start = 1'b0;
    chk("fs_before_last_load", int'(bus.conv_start), 0);
    load_range(TOTAL - 1, TOTAL, 0);

    // feed_start beats a simultaneous load in READY; 0xAA must not land at index 0
    bus.feed_start = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hAA;
    #1;
    chk("ready_low_on_feed_start", int'(bus.load_ready), 0);
    @(negedge clk);
    bus.feed_start = 1'b0;
    bus.load_valid = 1'b0;
    chk("feed1_entered", int'(bus.conv_start), 1);
    run_feed("feed1", 0, 0, p0);
    chk("feed1_pix0_stored_value", p0, 0);
    chk("ready_after_done", int'(bus.load_ready), 1);

    // replay without reload, with 1,0,0,1 backpressure
    bus.feed_start = 1'b1;
    @(negedge clk);
    bus.feed_start = 1'b0;
    chk("feed2_entered", int'(bus.conv_start), 1);
    run_feed("feed2", 1, 0, p0);

    // reset in the middle of a feed
    bus.feed_start = 1'b1;
    @(negedge clk);
    bus.feed_start = 1'b0;
    run_feed("feed3", 0, 500, p0);
    bus.need_pic = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_async_pic_valid", int'(bus.pic_valid), 0);
    chk("rst_async_conv_start", int'(bus.conv_start), 0);
    chk("rst_async_pic", int'(bus.pic), 0);
    chk("rst_async_pic_addr", int'(bus.pic_addr), 0);
    chk("rst_async_load_ready", int'(bus.load_ready), 0);
    seen_fd = 0;
    seen_cs = 0;
    repeat (2) begin
      @(negedge clk);
      seen_fd |= int'(bus.feed_done);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_load_ready", int'(bus.load_ready), 1);
    bus.feed_start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen_cs |= int'(bus.conv_start);
      seen_fd |= int'(bus.feed_done);
    end
    bus.feed_start = 1'b0;
    bus.need_pic   = 1'b0;
    chk("post_rst_fs_ignored", seen_cs, 0);
    chk("post_rst_no_done", seen_fd, 0);

    // full reload with gaps, then a READY load restarts the image at index 0
    foreach (model[i]) model[i] = (i * 7 + 3) % 256;
    load_range(0, TOTAL, 5);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h55;
    #1;
    chk("ready_restart_load_ready", int'(bus.load_ready), 1);
    @(negedge clk);
    bus.load_valid = 1'b0;
    model[0] = 8'h55;
    bus.feed_start = 1'b1;
    @(negedge clk);
    bus.feed_start = 1'b0;
    chk("fs_after_restart_ignored", int'(bus.conv_start), 0);
    load_range(1, TOTAL, 0);
    bus.feed_start = 1'b1;
    @(negedge clk);
    bus.feed_start = 1'b0;
    chk("feed4_entered", int'(bus.conv_start), 1);
    run_feed("feed4", 0, 0, p0);
    chk("feed4_pix0_restart_value", p0, 8'h55);

    chk("load_ready_during_loads", ld_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
